// File: rtl/fetch_stage.sv
// fetch_stage: RV32I IF stage and IF/ID register with a variable-latency
// imem handshake, EX/ID redirects and hazard stall/flush handling.
//
// Ports:
//   clk, reset_x        clock, async active-low reset
//   Fo_imemReq/Addr     fetch request and word-aligned address
//   Fi_imemValid/Inst   response completing the outstanding request
//   Fi_stall, Di_flush  hazard stall (hold) and flush (bubble IF/ID)
//   Di_jal/JalTarget    jal redirect from ID
//   Ei_redirect/PC      branch/jalr redirect from EX (highest priority)
//   Do_inst/pc/pcPlus4/valid  IF/ID register contents
//   Fo_fetchCnt/bubbleCnt     perf counters, only with FETCH_PERF_CNT_EN
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_x,
  output logic        Fo_imemReq,
  output logic [31:0] Fo_imemAddr,
  input  logic        Fi_imemValid,
  input  logic [31:0] Fi_imemInst,
  input  logic        Fi_stall,
  input  logic        Di_flush,
  input  logic        Di_jal,
  input  logic [31:0] Di_jalTarget,
  input  logic        Ei_redirect,
  input  logic [31:0] Ei_redirectPC,
  output logic [31:0] Do_inst,
  output logic [31:0] Do_pc,
  output logic [31:0] Do_pcPlus4,
  output logic        Do_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] Fo_fetchCnt,
  output logic [31:0] Fo_bubbleCnt
`endif
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    KILL
  } state_t;

  typedef enum logic [1:0] {
    OP_KEEP,
    OP_BUB,
    OP_MEM,
    OP_HELD
  } ifid_op_t;

  state_t      state;
  ifid_op_t    op;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] held_inst;
  logic [31:0] saved_tgt;
  logic        jal_take;
  logic        redir;
  logic [31:0] tgt;

  // In KILL the ID instruction is already wrong-path, so its jal is moot.
  assign jal_take = Di_jal & ~Fi_stall & ~Ei_redirect
                  & (state != KILL);
  assign redir    = Ei_redirect | jal_take;
  assign tgt      = Ei_redirect ? Ei_redirectPC : Di_jalTarget;
  assign pc_plus4 = pc + 32'd4;

  assign Fo_imemReq  = (state != HOLD);
  assign Fo_imemAddr = {pc[31:2], 2'b00};

  always_comb begin
    op = OP_KEEP;
    if (redir || Di_flush)
      op = OP_BUB;
    else if (Fi_stall)
      op = OP_KEEP;
    else if (state == HOLD)
      op = OP_HELD;
    else if (state == FETCH && Fi_imemValid)
      op = OP_MEM;
    else
      op = OP_BUB;
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      held_inst <= '0;
      saved_tgt <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (redir) begin
            if (Fi_imemValid) begin
              pc <= tgt;
            end else begin
              saved_tgt <= tgt;
              state     <= KILL;
            end
          end else if (Fi_imemValid) begin
            if (Fi_stall) begin
              held_inst <= Fi_imemInst;
              state     <= HOLD;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        HOLD: begin
          if (redir) begin
            pc    <= tgt;
            state <= FETCH;
          end else if (!Fi_stall) begin
            pc    <= pc_plus4;
            state <= FETCH;
          end
        end
        KILL: begin
          // Wait out the stale response; newest EX target wins.
          if (Fi_imemValid) begin
            pc    <= Ei_redirect ? Ei_redirectPC : saved_tgt;
            state <= FETCH;
          end else if (Ei_redirect) begin
            saved_tgt <= Ei_redirectPC;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      Do_inst    <= NOP_INST;
      Do_pc      <= RESET_PC;
      Do_pcPlus4 <= RESET_PC + 32'd4;
      Do_valid   <= 1'b0;
    end else begin
      unique case (op)
        OP_BUB: begin
          Do_inst  <= NOP_INST;
          Do_valid <= 1'b0;
        end
        OP_MEM: begin
          Do_inst    <= Fi_imemInst;
          Do_pc      <= pc;
          Do_pcPlus4 <= pc_plus4;
          Do_valid   <= 1'b1;
        end
        OP_HELD: begin
          Do_inst    <= held_inst;
          Do_pc      <= pc;
          Do_pcPlus4 <= pc_plus4;
          Do_valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (op == OP_MEM || op == OP_HELD)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (op == OP_BUB)
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign Fo_fetchCnt  = fetch_cnt;
  assign Fo_bubbleCnt = bubble_cnt;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage RV32I pipeline.
- Owns the PC and issues requests to instruction memory over a variable-latency req/valid handshake.
- Applies EX-stage redirects (branch/jalr), ID-stage jal redirects, and hazard stall/flush.
- Drives Do_inst/Do_pc into the decode stage and the controller.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) written into IF/ID.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_x  input  1  asynchronous active-low reset.
- Fo_imemReq  output  1  instruction fetch request.
- Fo_imemAddr  output  32  fetch address, word aligned.
- Fi_imemValid  input  1  response valid; completes the outstanding request this cycle.
- Fi_imemInst  input  32  instruction data, sampled when Fi_imemValid=1.
- Fi_stall  input  1  hazard stall; holds PC and IF/ID.
- Di_flush  input  1  hazard flush; IF/ID loads bubble.
- Di_jal  input  1  jal decoded in ID.
- Di_jalTarget  input  32  jal target.
- Ei_redirect  input  1  taken branch or jalr resolved in EX.
- Ei_redirectPC  input  32  EX redirect target.
- Do_inst  output  32  IF/ID instruction.
- Do_pc  output  32  IF/ID PC.
- Do_pcPlus4  output  32  IF/ID PC+4.
- Do_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, reset_x=0):
  - PC=RESET_PC, state=FETCH.
  - Do_inst=NOP_INST, Do_pc=RESET_PC, Do_pcPlus4=RESET_PC+4, Do_valid=0.
  - Held and saved-target registers cleared to 0.
  - First request issues in the first cycle after deassertion.
- Handshake:
  - One outstanding request at most.
  - While Fo_imemReq=1, Fo_imemAddr must stay constant until the cycle in which Fi_imemValid=1.
  - Same-cycle response gives 1 instruction per cycle.
  - Fi_imemValid while Fo_imemReq=0 is ignored.
- Redirect priority: Ei_redirect > Di_jal.
  - Di_jal is ignored when Fi_stall=1 or Ei_redirect=1.
  - A redirect forces IF/ID to bubble (Do_valid=0, Do_inst=NOP_INST) at the next edge, independent of Di_flush.
- State FETCH (Fo_imemReq=1, Fo_imemAddr=PC):
  - Redirect, valid=1: response dropped; PC<=target; stay FETCH.
  - Redirect, valid=0: target saved; go KILL.
  - No redirect, valid=1, Fi_stall=0: IF/ID<={Fi_imemInst, PC, PC+4, 1}; PC<=PC+4.
  - No redirect, valid=1, Fi_stall=1: instruction captured into held register; IF/ID unchanged; go HOLD.
  - No redirect, valid=0: if Fi_stall=0, IF/ID<=bubble; if Fi_stall=1, IF/ID held; PC held.
- State HOLD (Fo_imemReq=0):
  - Redirect: held instruction discarded; PC<=target; go FETCH.
  - Fi_stall=1: remain in HOLD.
  - Fi_stall=0: IF/ID<={held, PC, PC+4, 1}; PC<=PC+4; go FETCH.
- State KILL (Fo_imemReq=1, Fo_imemAddr=old PC):
  - A new Ei_redirect overwrites the saved target; newest wins.
  - valid=1: response dropped; PC<=saved target, or the new Ei_redirectPC if asserted the same cycle; go FETCH.
  - IF/ID: bubble unless Fi_stall=1.
- Flush and stall:
  - Di_flush=1 with Fi_stall=0: IF/ID<=bubble; PC update proceeds as per state.
  - Di_flush and Fi_stall both set: flush wins for IF/ID only.
- Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Alignment: targets are used as given; bits [1:0] are forced to 0 on Fo_imemAddr.
- Reset mid-request: outstanding request is abandoned; a late Fi_imemValid after reset, before the first request, is ignored.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Enabled:
  - Adds outputs Fo_fetchCnt[31:0] (increments per instruction loaded into IF/ID with Do_valid=1).
  - Adds Fo_bubbleCnt[31:0] (increments per cycle IF/ID loads a bubble).
  - Both counters reset to 0 and wrap modulo 2^32.
- Disabled: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, zero-latency memory returning inst=addr+0x100 -> Do_pc 0,4,8,12 on consecutive cycles, Do_valid=1 from cycle 2.
- 3-cycle memory latency -> Fo_imemAddr held at 0x4 for 3 cycles, two bubbles into IF/ID, then Do_pc=0x4.
- Ei_redirect to 0x80 while a 2-cycle request to 0x8 is pending -> KILL, 0x8 data dropped, next Fo_imemAddr=0x80, Do_valid=0 until 0x80 returns.
- Fi_stall for 3 cycles with valid arriving in the first -> HOLD, Fo_imemReq=0, IF/ID unchanged, instruction delivered the cycle after stall drops.
- Same cycle Ei_redirect=0x200 and Di_jal=0x300 -> PC=0x200.
- RESET_PC=32'hFFFF_FFFC -> second Fo_imemAddr=0x0.
